// File: rtl/gcu_buf_pkg.sv
// rtl/gcu_buf_pkg.sv - shared types and constants for the GCU buffer scheduler
//
// Purpose: per-buffer lifecycle state encoding and the protocol-error flag
//          value used when a completion pulse arrives in the wrong state.
// Ports:   none (package).

package gcu_buf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    READY,
    PROCESSING,
    WRITEBACK
  } buf_state_e;

  localparam logic ERR_FLAG_SET = 1'b1;

endpackage

// File: rtl/gcu_rr_pick.sv
// rtl/gcu_rr_pick.sv - round-robin picker: first set request at or after a pointer
//
// Purpose: scans req_i starting at ptr_i, wrapping past N-1 to 0, and returns
//          the index of the first asserted request.
// Ports:
//   req_i    in  N      request vector
//   ptr_i    in  IDX_W  starting index (must be < N)
//   grant_o  out IDX_W  chosen index (0 when nothing requested)
//   valid_o  out 1      at least one request is set

module gcu_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             valid_o
);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request to ptr_i wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[wrap_idx(ptr_i, k)]) begin
        grant_o = wrap_idx(ptr_i, k);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcu_buffer_sched.sv
// rtl/gcu_buffer_sched.sv - N-buffer task scheduler for the GCU front end
//
// Purpose: accepts node tasks, allocates them round-robin to idle staging
//          buffers, requests front loads, dispatches loaded buffers to the
//          compute core and recycles each buffer after compute + writeback.
// Build option: GCU_BUF_AGE_ORDER_EN selects oldest-first dispatch using
//          per-allocation sequence tags; otherwise dispatch is round-robin.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   task_valid/task_ready/task_in task handshake and descriptor
//   front_ready_for_task          front loader can take a request
//   front_load_req                one-cycle load request per buffer
//   front_load_addr/dim           per-buffer slices of the latched task
//   front_load_done               per-buffer load complete pulse
//   disp_valid/disp_ready         dispatch handshake to compute
//   disp_idx/disp_task            offered buffer index and its task
//   node_compute_done             per-buffer compute complete pulse
//   writeback_done                per-buffer writeback complete pulse
//   buf_busy                      buffer not IDLE
//   idle_cnt                      number of IDLE buffers
//   err_proto                     sticky completion-in-wrong-state flag

module gcu_buffer_sched
  import gcu_buf_pkg::*;
#(
  parameter int  BUFFER_NUM     = 4,
  parameter int  TASK_W         = 128,
  parameter int  FRONT_ADDR_W   = 32,
  parameter int  FRONT_ADDR_LSB = 0,
  parameter int  FRONT_DIM_W    = 16,
  parameter int  FRONT_DIM_LSB  = 32,
  localparam int IDX_W          = $clog2(BUFFER_NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                task_valid,
  output logic                                task_ready,
  input  logic [TASK_W-1:0]                   task_in,
  input  logic                                front_ready_for_task,
  output logic [BUFFER_NUM-1:0]               front_load_req,
  output logic [BUFFER_NUM*FRONT_ADDR_W-1:0]  front_load_addr,
  output logic [BUFFER_NUM*FRONT_DIM_W-1:0]   front_load_dim,
  input  logic [BUFFER_NUM-1:0]               front_load_done,
  output logic                                disp_valid,
  input  logic                                disp_ready,
  output logic [IDX_W-1:0]                    disp_idx,
  output logic [TASK_W-1:0]                   disp_task,
  input  logic [BUFFER_NUM-1:0]               node_compute_done,
  input  logic [BUFFER_NUM-1:0]               writeback_done,
  output logic [BUFFER_NUM-1:0]               buf_busy,
  output logic [IDX_W:0]                      idle_cnt,
  output logic                                err_proto
);

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(BUFFER_NUM - 1)) ? '0 : i + 1'b1;
  endfunction

  buf_state_e              state_q    [BUFFER_NUM];
  logic [TASK_W-1:0]       buf_task_q [BUFFER_NUM];
  logic [BUFFER_NUM-1:0]   load_req_q;
  logic [IDX_W-1:0]        alloc_ptr_q;
  logic                    err_q;
  logic                    lock_q;
  logic [IDX_W-1:0]        lock_idx_q;

  logic [BUFFER_NUM-1:0]   idle_vec;
  logic [BUFFER_NUM-1:0]   ready_vec;
  logic [BUFFER_NUM-1:0]   proto_err_vec;
  logic [IDX_W-1:0]        alloc_idx;
  logic                    alloc_ok;
  logic                    task_fire;
  logic [IDX_W-1:0]        cand_idx;
  logic                    cand_valid;
  logic [IDX_W-1:0]        sel_idx;
  logic                    disp_fire;

  always_comb begin
    idle_vec      = '0;
    ready_vec     = '0;
    proto_err_vec = '0;
    for (int i = 0; i < BUFFER_NUM; i++) begin
      idle_vec[i]      = (state_q[i] == IDLE);
      ready_vec[i]     = (state_q[i] == READY);
      proto_err_vec[i] = (front_load_done[i]   && (state_q[i] != LOADING))    ||
                         (node_compute_done[i] && (state_q[i] != PROCESSING)) ||
                         (writeback_done[i]    && (state_q[i] != WRITEBACK));
    end
  end

  always_comb begin
    idle_cnt = '0;
    for (int i = 0; i < BUFFER_NUM; i++) begin
      idle_cnt = idle_cnt + {{IDX_W{1'b0}}, idle_vec[i]};
    end
  end

  // task_ready depends only on registered state, so a buffer freed at an edge
  // is not allocatable until the following cycle.
  assign task_ready = front_ready_for_task && (idle_cnt != '0);
  assign task_fire  = task_valid && task_ready && alloc_ok;
  assign buf_busy   = ~idle_vec;

  gcu_rr_pick #(.N(BUFFER_NUM), .IDX_W(IDX_W)) u_alloc_pick (
    .req_i   (idle_vec),
    .ptr_i   (alloc_ptr_q),
    .grant_o (alloc_idx),
    .valid_o (alloc_ok)
  );

`ifdef GCU_BUF_AGE_ORDER_EN
  // Age = distance back from the current counter; tags of outstanding buffers
  // span at most BUFFER_NUM values, which fits in half the counter range.
  logic [IDX_W:0] seq_q;
  logic [IDX_W:0] tag_q [BUFFER_NUM];
  logic [IDX_W:0] best_age;

  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = '0;
    best_age   = '0;
    for (int i = 0; i < BUFFER_NUM; i++) begin
      if (ready_vec[i] && (!cand_valid || ((seq_q - tag_q[i]) > best_age))) begin
        cand_valid = 1'b1;
        cand_idx   = IDX_W'(i);
        best_age   = seq_q - tag_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
      for (int i = 0; i < BUFFER_NUM; i++) tag_q[i] <= '0;
    end else if (task_fire) begin
      seq_q            <= seq_q + 1'b1;
      tag_q[alloc_idx] <= seq_q;
    end
  end
`else
  logic [IDX_W-1:0] disp_ptr_q;

  gcu_rr_pick #(.N(BUFFER_NUM), .IDX_W(IDX_W)) u_disp_pick (
    .req_i   (ready_vec),
    .ptr_i   (disp_ptr_q),
    .grant_o (cand_idx),
    .valid_o (cand_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_ptr_q <= '0;
    end else if (disp_fire) begin
      disp_ptr_q <= inc_wrap(sel_idx);
    end
  end
`endif

  // An offer left pending is pinned so a newly READY buffer cannot replace it.
  assign sel_idx    = lock_q ? lock_idx_q : cand_idx;
  assign disp_valid = lock_q || cand_valid;
  assign disp_fire  = disp_valid && disp_ready;
  assign disp_idx   = disp_valid ? sel_idx : '0;
  assign disp_task  = disp_valid ? buf_task_q[sel_idx] : '0;

  assign front_load_req = load_req_q;
  assign err_proto      = err_q;

  for (genvar g = 0; g < BUFFER_NUM; g++) begin : g_slice
    assign front_load_addr[g*FRONT_ADDR_W +: FRONT_ADDR_W] =
      buf_task_q[g][FRONT_ADDR_LSB +: FRONT_ADDR_W];
    assign front_load_dim[g*FRONT_DIM_W +: FRONT_DIM_W] =
      buf_task_q[g][FRONT_DIM_LSB +: FRONT_DIM_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_NUM; i++) begin
        state_q[i]    <= IDLE;
        buf_task_q[i] <= '0;
      end
      load_req_q  <= '0;
      alloc_ptr_q <= '0;
      err_q       <= 1'b0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      load_req_q <= '0;
      lock_q     <= disp_valid && !disp_ready;
      lock_idx_q <= sel_idx;
      if (task_fire) alloc_ptr_q <= inc_wrap(alloc_idx);
      for (int i = 0; i < BUFFER_NUM; i++) begin
        case (state_q[i])
          IDLE: begin
            if (task_fire && (alloc_idx == IDX_W'(i))) begin
              state_q[i]    <= LOADING;
              buf_task_q[i] <= task_in;
              load_req_q[i] <= 1'b1;
            end
          end
          LOADING:    if (front_load_done[i])   state_q[i] <= READY;
          READY:      if (disp_fire && (sel_idx == IDX_W'(i))) state_q[i] <= PROCESSING;
          PROCESSING: if (node_compute_done[i]) state_q[i] <= WRITEBACK;
          WRITEBACK:  if (writeback_done[i])    state_q[i] <= IDLE;
          default:    state_q[i] <= IDLE;
        endcase
      end
      if (|proto_err_vec) err_q <= ERR_FLAG_SET;
    end
  end

endmodule

// File: tb/tb_gcu_buffer_sched.sv
// tb/tb_gcu_buffer_sched.sv - directed self-checking bench for gcu_buffer_sched

module tb_gcu_buffer_sched;

  logic         clk;
  logic         rst;
  logic         task_valid;
  logic         task_ready;
  logic [127:0] task_in;
  logic         front_ready_for_task;
  logic [3:0]   front_load_req;
  logic [127:0] front_load_addr;
  logic [63:0]  front_load_dim;
  logic [3:0]   front_load_done;
  logic         disp_valid;
  logic         disp_ready;
  logic [1:0]   disp_idx;
  logic [127:0] disp_task;
  logic [3:0]   node_compute_done;
  logic [3:0]   writeback_done;
  logic [3:0]   buf_busy;
  logic [2:0]   idle_cnt;
  logic         err_proto;

  int n_chk = 0;
  int n_err = 0;

  gcu_buffer_sched #(.BUFFER_NUM(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .task_valid           (task_valid),
    .task_ready           (task_ready),
    .task_in              (task_in),
    .front_ready_for_task (front_ready_for_task),
    .front_load_req       (front_load_req),
    .front_load_addr      (front_load_addr),
    .front_load_dim       (front_load_dim),
    .front_load_done      (front_load_done),
    .disp_valid           (disp_valid),
    .disp_ready           (disp_ready),
    .disp_idx             (disp_idx),
    .disp_task            (disp_task),
    .node_compute_done    (node_compute_done),
    .writeback_done       (writeback_done),
    .buf_busy             (buf_busy),
    .idle_cnt             (idle_cnt),
    .err_proto            (err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_task(input int k);
    logic [127:0] t;
    t = '0;
    t[127:120] = 8'hA0 + 8'(k);
    t[47:32]   = 16'(k + 2);
    t[31:0]    = 32'(k);
    return t;
  endfunction

  function automatic logic [31:0] addr_of(input int b);
    return front_load_addr[b*32 +: 32];
  endfunction

  function automatic logic [15:0] dim_of(input int b);
    return front_load_dim[b*16 +: 16];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    task_valid = 1'b0;
    task_in = '0;
    front_ready_for_task = 1'b0;
    front_load_done = '0;
    disp_ready = 1'b0;
    node_compute_done = '0;
    writeback_done = '0;

    repeat (2) tick();
    chk("rst_busy",   buf_busy, 0);
    chk("rst_idle",   idle_cnt, 4);
    chk("rst_dvalid", disp_valid, 0);
    chk("rst_req",    front_load_req, 0);
    chk("rst_err",    err_proto, 0);
    chk("rst_tready", task_ready, 0);

    rst = 1'b0;
    front_ready_for_task = 1'b1;
    tick();
    chk("tready_empty", task_ready, 1);

    // Four back-to-back tasks fill buffers 0..3 in order.
    task_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      task_in = mk_task(i + 1);
      tick();
      chk("ld_req",  front_load_req, 128'(4'b0001 << i));
      chk("ld_addr", addr_of(i), 128'(i + 1));
      chk("ld_dim",  dim_of(i), 128'(i + 3));
    end
    chk("full_idle",   idle_cnt, 0);
    chk("full_tready", task_ready, 0);
    task_valid = 1'b0;
    task_in = '0;
    tick();
    chk("req_pulse_end", front_load_req, 0);
    chk("addr_held",     addr_of(0), 1);

    // Buffers 2 and 0 finish loading; buffer 0 goes first.
    front_load_done = 4'b0101;
    tick();
    front_load_done = '0;
    chk("d1_valid", disp_valid, 1);
    chk("d1_idx",   disp_idx, 0);
    chk("d1_task",  disp_task, mk_task(1));
    disp_ready = 1'b1;
    tick();
    disp_ready = 1'b0;
    chk("d2_idx",  disp_idx, 2);
    chk("d2_task", disp_task, mk_task(3));

    // Offer of buffer 2 stays pinned while older buffer 1 becomes READY.
    tick();
    front_load_done = 4'b0010;
    tick();
    front_load_done = '0;
    chk("lock_idx", disp_idx, 2);
    tick();
    chk("lock_idx_hold", disp_idx, 2);
    disp_ready = 1'b1;
    tick();
    chk("after_lock_idx", disp_idx, 1);
    tick();
    disp_ready = 1'b0;
    chk("none_ready", disp_valid, 0);

    // Compute-done on a LOADING buffer is a protocol error, state unchanged.
    node_compute_done = 4'b1000;
    tick();
    node_compute_done = '0;
    chk("err_set",    err_proto, 1);
    chk("err_busy",   buf_busy, 4'hF);
    chk("err_nodisp", disp_valid, 0);
    front_load_done = 4'b1000;
    tick();
    front_load_done = '0;
    chk("b3_valid",   disp_valid, 1);
    chk("b3_idx",     disp_idx, 3);
    chk("err_sticky", err_proto, 1);

    // Writeback frees buffer 1; the pending task lands there one cycle later.
    node_compute_done = 4'b0111;
    tick();
    node_compute_done = '0;
    task_valid = 1'b1;
    task_in = mk_task(5);
    chk("wb_full_tready", task_ready, 0);
    writeback_done = 4'b0010;
    tick();
    writeback_done = '0;
    chk("wb_tready",        task_ready, 1);
    chk("wb_idle",          idle_cnt, 1);
    chk("wb_no_same_edge",  front_load_req, 0);
    tick();
    task_valid = 1'b0;
    task_in = '0;
    chk("wb_alloc_req",  front_load_req, 4'b0010);
    chk("wb_alloc_addr", addr_of(1), 5);
    chk("wb_idle0",      idle_cnt, 0);

    // Asynchronous reset with buffers in mixed states.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy",   buf_busy, 0);
    chk("arst_idle",   idle_cnt, 4);
    chk("arst_dvalid", disp_valid, 0);
    chk("arst_err",    err_proto, 0);
    chk("arst_req",    front_load_req, 0);
    chk("arst_task",   addr_of(1), 0);
    tick();
    rst = 1'b0;
    task_valid = 1'b1;
    task_in = mk_task(6);
    tick();
    task_valid = 1'b0;
    chk("post_rst_req",  front_load_req, 4'b0001);
    chk("post_rst_addr", addr_of(0), 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
